ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage, consuming the operand and decode fields registered by the ID/EX pipeline register. It detects M-extension instructions, computes them over multiple cycles, and raises a stall request so the front of the pipeline holds the instruction in ID/EX until the result is ready. Non-M instructions pass through untouched; the EX result mux selects this block's output only when `result_valid_o` is high.

## Interface
- `DATA_W`, 32: operand/result width; all special-case constants below are for 32.
- `clk`  input  1  pipeline clock, rising edge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `flush_i`  input  1  synchronous abort; highest priority after reset.
- `ex_opcode_i`  input  7  opcode from ID/EX.
- `ex_funct3_i`  input  3  funct3 from ID/EX.
- `ex_funct7_i`  input  7  funct7 from ID/EX.
- `ex_wreg_addr_i`  input  5  destination register.
- `ex_rs1_data_i`  input  DATA_W  rs1 operand.
- `ex_rs2_data_i`  input  DATA_W  rs2 operand.
- `result_o`  output  DATA_W  registered result; valid only with `result_valid_o`.
- `result_wreg_addr_o`  output  5  destination latched at issue.
- `result_valid_o`  output  1  one-cycle result strobe.
- `stallreq_muldiv_o`  output  1  stall request to the pipeline hold logic.

## Operation
- Issue condition `start` = state IDLE && opcode == 7'b0110011 && funct7 == 7'b0000001 && !flush_i.
- funct3: 000 MUL (low 32), 001 MULH (s×s high), 010 MULHSU (s×u high), 011 MULHU (u×u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- On start: latch funct3, wreg_addr, operand magnitudes (two's-complement absolute value for signed operands), and result sign.
  - MUL/MULH/MULHSU sign = XOR of the signed operands' signs.
  - DIV quotient sign = sign(rs1) XOR sign(rs2).
  - REM sign = sign(rs1).
- States: IDLE, CALC, DONE.
  - IDLE→CALC on a normal start.
  - IDLE→DONE on a special-case start.
  - CALC→DONE when the 5-bit iteration counter reaches 31.
  - DONE→IDLE unconditionally.
- Multiply: radix-2 shift-add over a 64-bit accumulator, 32 iterations. Negate the 64-bit product if sign is set; select the low or high half per funct3.
- Divide: restoring, 32 iterations, 33-bit partial remainder. Negate the quotient or remainder per sign at completion.
- Special cases, resolved at issue with no iteration:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- DONE never issues, regardless of inputs. The same instruction is still visible on the inputs in DONE and must not be restarted.
- `flush_i`: state→IDLE, counter cleared, `result_valid_o` forced 0 next cycle. Any in-flight result is discarded.

## Timing
- Reset values: state IDLE, counter 0, `result_o` 0, `result_wreg_addr_o` 0, `result_valid_o` 0, `stallreq_muldiv_o` 0.
- `stallreq_muldiv_o` = start || state == CALC || (state IDLE→DONE special-case issue cycle). It is combinational, so it is high in the issue cycle itself.
- Normal op issued in cycle T:
  - Stall high T..T+32.
  - CALC occupies T+1..T+32.
  - DONE at T+33: `result_valid_o` = 1, `result_o` valid, stall 0.
  - The pipeline advances at the end of T+33.
- Special case issued at T: stall high at T only; DONE at T+1 with the result.
- Back-to-back M instructions: the second issues the cycle after DONE, with no overlap.
- Non-M instruction in IDLE: no stall, no valid; outputs hold their last values.
- `flush_i` during the issue cycle suppresses start.
- `flush_i` in CALC: stall drops the cycle after flush is sampled.
- Reset mid-operation: all outputs return to reset values asynchronously.

## Test plan
- MUL rs1 = 7, rs2 = 0xFFFFFFFD at T -> stall T..T+32; at T+33 valid = 1, `result_o` = 0xFFFFFFEB, wreg_addr echoed.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULH of the same operands -> 0x00000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD at T+33. REM of the same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 0x1234 / 0 -> 0xFFFFFFFF at T+1 with stall only at T. REM 0x1234 / 0 -> 0x1234. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- Hold the MUL inputs static through DONE -> exactly one valid pulse and no restart. Then present the next MUL at T+34 -> it issues at T+34.
- `flush_i` at T+10 of a DIV -> IDLE at T+11, no valid pulse. Separately, `rst_n` low at T+5 -> all outputs 0 immediately, and a fresh op after release completes correctly.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage.
// A multiply is a 32-step radix-2 shift-add and a divide is a 32-step restoring
// divide. Both work on operand magnitudes and fix the sign once at completion.
// Divide-by-zero and signed overflow are resolved at issue without iterating.
module ex_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic [6:0]        ex_opcode_i,
    input  logic [2:0]        ex_funct3_i,
    input  logic [6:0]        ex_funct7_i,
    input  logic [4:0]        ex_wreg_addr_i,
    input  logic [DATA_W-1:0] ex_rs1_data_i,
    input  logic [DATA_W-1:0] ex_rs2_data_i,
    output logic [DATA_W-1:0] result_o,
    output logic [4:0]        result_wreg_addr_o,
    output logic              result_valid_o,
    output logic              stallreq_muldiv_o
);

    localparam logic [6:0]        OPC_OP    = 7'b0110011;
    localparam logic [6:0]        F7_MULDIV = 7'b0000001;
    localparam logic [DATA_W-1:0] INT_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                neg_q, neg_d;
    logic [DATA_W-1:0]   op_q, op_d;        // multiplicand, or divisor
    logic [2*DATA_W-1:0] acc_q, acc_d;      // {hi, lo}: product, or {remainder, quotient}
    logic [DATA_W-1:0]   result_q, result_d;
    logic [4:0]          wreg_q, wreg_d;
    logic                valid_q, valid_d;

    // Issue-time decode
    logic                op1_signed, op2_signed, rs1_neg, rs2_neg, sign_in;
    logic                div_by_zero, div_ovf, special, start;
    logic [DATA_W-1:0]   mag1, mag2, special_val;

    // Iteration datapath
    logic [DATA_W:0]     mul_sum, div_part;
    logic                div_ge;
    logic [DATA_W-1:0]   div_diff, quo_fin, rem_fin, final_val;
    logic [2*DATA_W-1:0] mul_next, div_next, acc_next, prod_fin;

    // Decode operand signedness, magnitudes, result sign and special cases at issue.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        op1_signed = 1'b0;
        op2_signed = 1'b0;
        case (ex_funct3_i)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                op1_signed = 1'b1;
                op2_signed = 1'b1;
            end
            3'b010:  op1_signed = 1'b1;
            default: ;
        endcase
        rs1_neg = op1_signed & ex_rs1_data_i[DATA_W-1];
        rs2_neg = op2_signed & ex_rs2_data_i[DATA_W-1];
        mag1    = rs1_neg ? -ex_rs1_data_i : ex_rs1_data_i;
        mag2    = rs2_neg ? -ex_rs2_data_i : ex_rs2_data_i;
        // Remainders take the dividend's sign; everything else the XOR of signs.
        sign_in = (ex_funct3_i[2] && ex_funct3_i[1]) ? rs1_neg : (rs1_neg ^ rs2_neg);

        div_by_zero = ex_funct3_i[2] && (ex_rs2_data_i == '0);
        div_ovf     = ex_funct3_i[2] && !ex_funct3_i[0] &&
                      (ex_rs1_data_i == INT_MIN) && (ex_rs2_data_i == '1);
        special     = div_by_zero || div_ovf;
        if (div_by_zero) special_val = ex_funct3_i[1] ? ex_rs1_data_i : '1;
        else             special_val = ex_funct3_i[1] ? '0 : INT_MIN;

        // Gated by rst_n so the stall request also reads 0 while reset is held.
        start = rst_n && (state_q == S_IDLE) && !flush_i &&
                (ex_opcode_i == OPC_OP) && (ex_funct7_i == F7_MULDIV);
    end

    // One shift-add or restoring-divide step, plus sign fix-up of the final value.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, op_q} : '0);
        mul_next = {mul_sum, acc_q[DATA_W-1:1]};

        div_part = acc_q[2*DATA_W-1:DATA_W-1];
        div_ge   = div_part >= {1'b0, op_q};
        div_diff = div_part[DATA_W-1:0] - op_q;
        div_next = div_ge ? {div_diff, acc_q[DATA_W-2:0], 1'b1}
                          : {acc_q[2*DATA_W-2:0], 1'b0};

        acc_next = funct3_q[2] ? div_next : mul_next;
        prod_fin = neg_q ? -acc_next : acc_next;
        quo_fin  = neg_q ? -acc_next[DATA_W-1:0] : acc_next[DATA_W-1:0];
        rem_fin  = neg_q ? -acc_next[2*DATA_W-1:DATA_W] : acc_next[2*DATA_W-1:DATA_W];

        case (funct3_q)
            3'b000:                 final_val = prod_fin[DATA_W-1:0];
            3'b001, 3'b010, 3'b011: final_val = prod_fin[2*DATA_W-1:DATA_W];
            3'b100, 3'b101:         final_val = quo_fin;
            default:                final_val = rem_fin;
        endcase
    end

    // Next-state and register-update logic for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        neg_d    = neg_q;
        op_d     = op_q;
        acc_d    = acc_q;
        result_d = result_q;
        wreg_d   = wreg_q;
        valid_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    funct3_d = ex_funct3_i;
                    wreg_d   = ex_wreg_addr_i;
                    neg_d    = sign_in;
                    op_d     = ex_funct3_i[2] ? mag2 : mag1;
                    acc_d    = {{DATA_W{1'b0}}, (ex_funct3_i[2] ? mag1 : mag2)};
                    cnt_d    = '0;
                    if (special) begin
                        result_d = special_val;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = acc_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    result_d = final_val;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;  // DONE never issues
        endcase

        // Flush discards any in-flight work and keeps the last reported result.
        if (flush_i) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            valid_d  = 1'b0;
            result_d = result_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register, datapath included, is reset so outputs are defined from cycle 0.
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            neg_q    <= 1'b0;
            op_q     <= '0;
            acc_q    <= '0;
            result_q <= '0;
            wreg_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            wreg_q   <= wreg_d;
            valid_q  <= valid_d;
        end
    end

    assign result_o           = result_q;
    assign result_wreg_addr_o = wreg_q;
    assign result_valid_o     = valid_q;
    assign stallreq_muldiv_o  = start || (state_q == S_CALC);

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed and randomized checks of ex_muldiv against an
// arithmetic reference model of the RV32M results and issue timing.
module tb_ex_muldiv;

    localparam logic [6:0]  OPC_OP  = 7'b0110011;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic [6:0]  ex_opcode_i = '0;
    logic [2:0]  ex_funct3_i = '0;
    logic [6:0]  ex_funct7_i = '0;
    logic [4:0]  ex_wreg_addr_i = '0;
    logic [31:0] ex_rs1_data_i = '0;
    logic [31:0] ex_rs2_data_i = '0;
    logic [31:0] result_o;
    logic [4:0]  result_wreg_addr_o;
    logic        result_valid_o;
    logic        stallreq_muldiv_o;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_res = '0;

    always #5 clk = ~clk;

    ex_muldiv #(.DATA_W(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .flush_i            (flush_i),
        .ex_opcode_i        (ex_opcode_i),
        .ex_funct3_i        (ex_funct3_i),
        .ex_funct7_i        (ex_funct7_i),
        .ex_wreg_addr_i     (ex_wreg_addr_i),
        .ex_rs1_data_i      (ex_rs1_data_i),
        .ex_rs2_data_i      (ex_rs2_data_i),
        .result_o           (result_o),
        .result_wreg_addr_o (result_wreg_addr_o),
        .result_valid_o     (result_valid_o),
        .stallreq_muldiv_o  (stallreq_muldiv_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // RV32M results from plain integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'h0, b});
        ovf = (a == INT_MIN) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return INT_MIN;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        return f3[2] && ((b == 0) || (!f3[0] && a == INT_MIN && b == 32'hFFFF_FFFF));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop();
        ex_opcode_i    = OPC_OP;
        ex_funct7_i    = 7'b0000000;
        ex_funct3_i    = 3'b000;
        ex_wreg_addr_i = 5'd0;
        ex_rs1_data_i  = '0;
        ex_rs2_data_i  = '0;
    endtask

    task automatic drive_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
        ex_opcode_i    = OPC_OP;
        ex_funct7_i    = 7'b0000001;
        ex_funct3_i    = f3;
        ex_wreg_addr_i = rd;
        ex_rs1_data_i  = a;
        ex_rs2_data_i  = b;
    endtask

    // Issue one M op in the next cycle, hold it on the inputs through DONE, and check it.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        int          lat;
        int          gap;
        logic [31:0] exp;
        exp = ref_result(f3, a, b);
        step();
        drive_m(f3, a, b, rd);
        #1;
        check({tag, "_issue_stall"}, 32'(stallreq_muldiv_o), 32'd1);
        check({tag, "_issue_valid"}, 32'(result_valid_o), 32'd0);
        lat = 0;
        gap = 0;
        do begin
            step();
            lat++;
            if (!result_valid_o && !stallreq_muldiv_o) gap++;
        end while (!result_valid_o && lat < 40);
        check({tag, "_latency"}, 32'(lat), is_special(f3, a, b) ? 32'd1 : 32'd33);
        check({tag, "_stall_gap"}, 32'(gap), 32'd0);
        check({tag, "_result"}, result_o, exp);
        check({tag, "_wreg"}, 32'(result_wreg_addr_o), 32'(rd));
        check({tag, "_done_stall"}, 32'(stallreq_muldiv_o), 32'd0);
        last_res = exp;
    endtask

    initial begin
        int          vcount;
        logic [2:0]  rf3;
        logic [31:0] ra, rb;

        // Reset state
        drive_nop();
        #12;
        check("rst_result", result_o, 32'h0);
        check("rst_wreg", 32'(result_wreg_addr_o), 32'h0);
        check("rst_valid", 32'(result_valid_o), 32'h0);
        check("rst_stall", 32'(stallreq_muldiv_o), 32'h0);
        #3 rst_n = 1'b1;

        // Directed multiply cases; the second MUL issues right after DONE of the first
        do_op("mul_7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
        do_op("mul_next", 3'b000, 32'h0000_1234, 32'h0000_0010, 5'd6);
        do_op("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        do_op("mulh_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
        do_op("mulhsu_ff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);

        // Directed divide cases
        do_op("div_-7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10);
        do_op("rem_-7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11);
        do_op("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd12);
        do_op("remu_100_7", 3'b111, 32'd100, 32'd7, 5'd13);

        // Special cases
        do_op("divu_by0", 3'b101, 32'h0000_1234, 32'h0, 5'd14);
        do_op("rem_by0", 3'b110, 32'h0000_1234, 32'h0, 5'd15);
        do_op("div_ovf", 3'b100, INT_MIN, 32'hFFFF_FFFF, 5'd16);
        do_op("rem_ovf", 3'b110, INT_MIN, 32'hFFFF_FFFF, 5'd17);
        do_op("divu_min_m1", 3'b101, INT_MIN, 32'hFFFF_FFFF, 5'd18);

        // Non-M instructions pass through
        step();
        drive_nop();
        ex_rs1_data_i = 32'd3;
        #1;
        check("nonm_add_stall", 32'(stallreq_muldiv_o), 32'd0);
        ex_opcode_i = 7'b0010011;
        ex_funct7_i = 7'b0000001;
        #1;
        check("nonm_opimm_stall", 32'(stallreq_muldiv_o), 32'd0);
        step();
        check("nonm_valid", 32'(result_valid_o), 32'd0);
        check("nonm_hold", result_o, last_res);

        // Flush in the issue cycle suppresses start
        drive_m(3'b100, 32'd100, 32'd7, 5'd20);
        flush_i = 1'b1;
        #1;
        check("flush_issue_stall", 32'(stallreq_muldiv_o), 32'd0);
        step();
        flush_i = 1'b0;
        drive_nop();
        #1;
        check("flush_issue_stall_after", 32'(stallreq_muldiv_o), 32'd0);
        vcount = 0;
        for (int i = 0; i < 36; i++) begin
            step();
            if (result_valid_o) vcount++;
        end
        check("flush_issue_no_valid", 32'(vcount), 32'd0);

        // Flush ten cycles into a divide
        step();
        drive_m(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd21);
        #1;
        check("flush_calc_issue", 32'(stallreq_muldiv_o), 32'd1);
        repeat (10) step();
        check("flush_calc_stall_t10", 32'(stallreq_muldiv_o), 32'd1);
        flush_i = 1'b1;
        drive_nop();
        step();
        flush_i = 1'b0;
        check("flush_calc_stall_t11", 32'(stallreq_muldiv_o), 32'd0);
        vcount = 0;
        for (int i = 0; i < 36; i++) begin
            if (result_valid_o) vcount++;
            step();
        end
        check("flush_calc_no_valid", 32'(vcount), 32'd0);
        check("flush_calc_hold", result_o, last_res);
        do_op("after_flush", 3'b101, 32'd1000, 32'd9, 5'd22);

        // Asynchronous reset mid-operation, with the instruction still presented
        step();
        drive_m(3'b000, 32'd123, 32'd456, 5'd23);
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_result", result_o, 32'h0);
        check("midrst_wreg", 32'(result_wreg_addr_o), 32'h0);
        check("midrst_valid", 32'(result_valid_o), 32'h0);
        check("midrst_stall", 32'(stallreq_muldiv_o), 32'h0);
        drive_nop();
        #3 rst_n = 1'b1;
        do_op("after_rst", 3'b000, 32'd123, 32'd456, 5'd24);

        // Randomized operations, biased toward boundary operands
        for (int n = 0; n < 40; n++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = INT_MIN; rb = 32'hFFFF_FFFF; end
                2: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            do_op($sformatf("rnd%0d_f%0d", n, rf3), rf3, ra, rb, 5'($urandom_range(1, 31)));
        end

        step();
        drive_nop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
